ssd_bcd_feeder: RTL and testbench

- Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble) with a digit scan sequencer.
- Takes a 14-bit binary value and produces four held BCD digits.
- Rotates a 2-bit digit selector on each refresh tick, presenting the selected digit. Outputs feed the seven-segment display driver directly (digit values plus active-digit index).
- Sits between application counters/registers and the display driver.

---
 rtl/ssd_pkg.sv | 36 +++
 rtl/ssd_bcd_feeder_bcd_add3_nibble.sv | 12 +
 rtl/ssd_bcd_feeder.sv | 138 +++++++++++++
 tb/tb_ssd_bcd_feeder.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared constants, FSM state encoding and the leading-zero blanking helper
// for the ssd_bcd_feeder binary-to-BCD display feeder.
package ssd_pkg;

  localparam int         DIGIT_W        = 4;
  localparam int         NUM_DIGITS     = 4;
  localparam int         SSD_MAX_VAL    = 9999;
  localparam logic [3:0] SSD_ERR_CODE   = 4'd13;
  localparam logic [3:0] SSD_BLANK_CODE = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // Blank zero digits from the thousands place downward; the units digit always shows.
  function automatic logic [DIGIT_W*NUM_DIGITS-1:0] blank_leading(
    input logic [DIGIT_W*NUM_DIGITS-1:0] d,
    input logic [DIGIT_W-1:0]            blank
  );
    logic [DIGIT_W*NUM_DIGITS-1:0] res;
    logic                          lead;
    res  = d;
    lead = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (lead && (d[i*DIGIT_W +: DIGIT_W] == '0)) begin
        res[i*DIGIT_W +: DIGIT_W] = blank;
      end else begin
        lead = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ssd_bcd_feeder_bcd_add3_nibble.sv
// Double-dabble correction for one BCD nibble: values of 5 or more get +3,
// wrapping within 4 bits (no carry out to the neighbouring nibble).
module bcd_add3_nibble
  import ssd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_nib,
  output logic [DIGIT_W-1:0] o_nib
);

  assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/ssd_bcd_feeder.sv
// Sequential double-dabble binary-to-BCD converter with held digits and a
// tick-driven digit scan. Optional: SSD_BCD_FEEDER_LEADING_ZERO_BLANK_EN.
module ssd_bcd_feeder
  import ssd_pkg::*;
#(
  parameter int         BIN_W      = 14,
  parameter int         MAX_VAL    = SSD_MAX_VAL,
  parameter logic [3:0] ERR_CODE   = SSD_ERR_CODE,
  parameter logic [3:0] BLANK_CODE = SSD_BLANK_CODE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [3:0]       digit0,
  output logic [3:0]       digit1,
  output logic [3:0]       digit2,
  output logic [3:0]       digit3,
  input  logic             scan_tick,
  output logic [1:0]       digit_sel,
  output logic [3:0]       digit_out
);

  localparam int ACC_W = DIGIT_W * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_W);

`ifdef SSD_BCD_FEEDER_LEADING_ZERO_BLANK_EN
  localparam bit LZB_EN = 1'b1;
`else
  localparam bit LZB_EN = 1'b0;
`endif

  state_t                   r_state;
  logic [BIN_W-1:0]         r_bin;
  logic [ACC_W-1:0]         r_bcd;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_ovf_pend;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_overflow;
  logic [ACC_W-1:0]         r_digits;
  logic [1:0]               r_sel;
  logic [3:0]               r_digit_out;

  logic [ACC_W-1:0]         w_bcd_adj;
  logic [ACC_W+BIN_W-1:0]   w_shift;
  logic [ACC_W-1:0]         w_bcd_next;
  logic [BIN_W-1:0]         w_bin_next;
  logic [ACC_W-1:0]         w_final;
  logic                     w_ovf_in;
  logic                     w_last;
  logic [1:0]               w_sel_next;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_add3
    bcd_add3_nibble u_add3 (
      .i_nib(r_bcd[gi*DIGIT_W +: DIGIT_W]),
      .o_nib(w_bcd_adj[gi*DIGIT_W +: DIGIT_W])
    );
  end

  assign w_shift    = {w_bcd_adj, r_bin} << 1;
  assign w_bcd_next = w_shift[ACC_W+BIN_W-1:BIN_W];
  assign w_bin_next = w_shift[BIN_W-1:0];
  assign w_ovf_in   = (32'(bin_in) > 32'(MAX_VAL));
  assign w_last     = (r_cnt == CNT_W'(BIN_W - 1));
  assign w_final    = LZB_EN ? blank_leading(w_bcd_next, BLANK_CODE) : w_bcd_next;

  // Digits load on the edge that completes the last shift, so they are valid
  // in the same cycle that done is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_digits   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_bin      <= bin_in;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= w_ovf_in;
            r_busy     <= 1'b1;
            r_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_bcd <= w_bcd_next;
          r_bin <= w_bin_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state    <= ST_LATCH;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_overflow <= r_ovf_pend;
            r_digits   <= r_ovf_pend ? {NUM_DIGITS{ERR_CODE}} : w_final;
          end
        end
        ST_LATCH: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Scan sequencer reads the held digits, so a tick on the load edge sees the old set.
  assign w_sel_next = r_sel + 2'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel       <= 2'd0;
      r_digit_out <= 4'd0;
    end else if (scan_tick) begin
      r_sel       <= w_sel_next;
      r_digit_out <= r_digits[{w_sel_next, 2'b00} +: 4];
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign overflow  = r_overflow;
  assign digit0    = r_digits[3:0];
  assign digit1    = r_digits[7:4];
  assign digit2    = r_digits[11:8];
  assign digit3    = r_digits[15:12];
  assign digit_sel = r_sel;
  assign digit_out = r_digit_out;

endmodule

// File: tb/tb_ssd_bcd_feeder.sv
// Directed self-checking bench for ssd_bcd_feeder: conversion latency, digits,
// overflow, ignored restarts, reset abort and digit scan behaviour.
module tb_ssd_bcd_feeder;

  logic        clk;
  logic        reset;
  logic [13:0] bin_in;
  logic        start;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [3:0]  digit0;
  logic [3:0]  digit1;
  logic [3:0]  digit2;
  logic [3:0]  digit3;
  logic        scan_tick;
  logic [1:0]  digit_sel;
  logic [3:0]  digit_out;

  int checks   = 0;
  int failures = 0;

`ifdef SSD_BCD_FEEDER_LEADING_ZERO_BLANK_EN
  localparam logic [3:0] LZ = 4'd15;
`else
  localparam logic [3:0] LZ = 4'd0;
`endif

  ssd_bcd_feeder dut (
    .clk      (clk),
    .reset    (reset),
    .bin_in   (bin_in),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .digit0   (digit0),
    .digit1   (digit1),
    .digit2   (digit2),
    .digit3   (digit3),
    .scan_tick(scan_tick),
    .digit_sel(digit_sel),
    .digit_out(digit_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts a conversion and returns the number of cycles until done (40 = timeout).
  task automatic run_conv(input logic [13:0] v, output int lat);
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, overflow} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=000", {busy, done, overflow});
    end
    checks++;
    if ({digit3, digit2, digit1, digit0} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_digits got=%h want=0000", {digit3, digit2, digit1, digit0});
    end
    checks++;
    if ({digit_sel, digit_out} !== 6'd0) begin
      failures++;
      $display("FAIL reset_scan got sel=%0d out=%0d want 0 0", digit_sel, digit_out);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL post_reset_idle got=%b want=00", {busy, done});
    end
    $display("test_reset: done");
  endtask

  task automatic test_convert_1234;
    int bad_busy;
    int bad_done;
    bad_busy = 0;
    bad_done = 0;
    @(negedge clk);
    bin_in = 14'd1234;
    start  = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy !== (c <= 14)) begin
        bad_busy++;
        $display("FAIL busy_cycle%0d got=%b want=%b", c, busy, (c <= 14));
      end
      if (done !== (c == 15)) begin
        bad_done++;
        $display("FAIL done_cycle%0d got=%b want=%b", c, done, (c == 15));
      end
    end
    checks++;
    if (bad_busy != 0) failures++;
    checks++;
    if (bad_done != 0) failures++;
    checks++;
    if ({digit3, digit2, digit1, digit0} !== 16'h1234) begin
      failures++;
      $display("FAIL digits_1234 got=%h want=1234", {digit3, digit2, digit1, digit0});
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_1234 got=%b want=0", overflow);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_one_cycle got=%b want=0", done);
    end
    $display("test_convert_1234: digits=%h", {digit3, digit2, digit1, digit0});
  endtask

  task automatic test_max_zero;
    int lat;
    run_conv(14'd9999, lat);
    checks++;
    if (lat != 15) begin
      failures++;
      $display("FAIL lat_9999 got=%0d want=15", lat);
    end
    checks++;
    if ({digit3, digit2, digit1, digit0} !== 16'h9999) begin
      failures++;
      $display("FAIL digits_9999 got=%h want=9999", {digit3, digit2, digit1, digit0});
    end
    run_conv(14'd0, lat);
    checks++;
    if ({digit3, digit2, digit1, digit0} !== {LZ, LZ, LZ, 4'd0}) begin
      failures++;
      $display("FAIL digits_0 got=%h want=%h", {digit3, digit2, digit1, digit0}, {LZ, LZ, LZ, 4'd0});
    end
    $display("test_max_zero: lat=%0d", lat);
  endtask

  task automatic test_overflow;
    int lat;
    run_conv(14'd10000, lat);
    checks++;
    if (lat != 15) begin
      failures++;
      $display("FAIL lat_10000 got=%0d want=15", lat);
    end
    checks++;
    if ({overflow, digit3, digit2, digit1, digit0} !== {1'b1, 16'hDDDD}) begin
      failures++;
      $display("FAIL ovf_10000 got ovf=%b dig=%h want ovf=1 dig=dddd",
               overflow, {digit3, digit2, digit1, digit0});
    end
    @(negedge clk);
    bin_in = 14'd5;
    start  = 1'b1;
    repeat (7) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if ({overflow, digit0} !== {1'b1, 4'd13}) begin
      failures++;
      $display("FAIL hold_during_conv got ovf=%b d0=%0d want 1 13", overflow, digit0);
    end
    lat = 7;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if ({overflow, digit3, digit2, digit1, digit0} !== {1'b0, LZ, LZ, LZ, 4'd5}) begin
      failures++;
      $display("FAIL after_ovf_5 got ovf=%b dig=%h want ovf=0 dig=%h",
               overflow, {digit3, digit2, digit1, digit0}, {LZ, LZ, LZ, 4'd5});
    end
    $display("test_overflow: lat5=%0d", lat);
  endtask

  task automatic test_restart_ignored;
    int ndone;
    int first_done;
    ndone      = 0;
    first_done = 0;
    @(negedge clk);
    bin_in = 14'd4321;
    start  = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first_done == 0) first_done = c;
      end
      start  = (c == 3 || c == 14 || c == 15);
      bin_in = (c == 3 || c == 14 || c == 15) ? 14'd7777 : 14'd4321;
    end
    start = 1'b0;
    checks++;
    if (ndone != 1 || first_done != 15) begin
      failures++;
      $display("FAIL restart_done got count=%0d at=%0d want count=1 at=15", ndone, first_done);
    end
    checks++;
    if ({digit3, digit2, digit1, digit0} !== 16'h4321) begin
      failures++;
      $display("FAIL restart_digits got=%h want=4321", {digit3, digit2, digit1, digit0});
    end
    $display("test_restart_ignored: dones=%0d", ndone);
  endtask

  task automatic test_reset_abort;
    int ndone;
    int lat;
    ndone = 0;
    @(negedge clk);
    bin_in = 14'd8888;
    start  = 1'b1;
    repeat (7) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, overflow, digit3, digit2, digit1, digit0} !== 19'd0) begin
      failures++;
      $display("FAIL abort_immediate got busy=%b dig=%h want 0 0000",
               busy, {digit3, digit2, digit1, digit0});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      failures++;
      $display("FAIL abort_no_done got=%0d want=0", ndone);
    end
    run_conv(14'd42, lat);
    checks++;
    if (lat != 15 || {digit3, digit2, digit1, digit0} !== {LZ, LZ, 8'h42}) begin
      failures++;
      $display("FAIL after_abort got lat=%0d dig=%h want 15 %h",
               lat, {digit3, digit2, digit1, digit0}, {LZ, LZ, 8'h42});
    end
    $display("test_reset_abort: lat=%0d", lat);
  endtask

  task automatic test_scan;
    int lat;
    logic [1:0] exp_sel [5];
    logic [3:0] exp_out [5];
    exp_sel = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_out = '{4'd3, 4'd2, 4'd1, 4'd4, 4'd3};
    run_conv(14'd1234, lat);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      scan_tick = 1'b1;
      @(negedge clk);
      scan_tick = 1'b0;
      checks++;
      if (digit_sel !== exp_sel[t] || digit_out !== exp_out[t]) begin
        failures++;
        $display("FAIL scan_tick%0d got sel=%0d out=%0d want sel=%0d out=%0d",
                 t, digit_sel, digit_out, exp_sel[t], exp_out[t]);
      end
    end
    // Tick sampled on the edge that loads 5678: must show the old hundreds digit.
    @(negedge clk);
    bin_in = 14'd5678;
    start  = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start     = 1'b0;
      scan_tick = (c == 14);
    end
    scan_tick = 1'b0;
    checks++;
    if (done !== 1'b1 || digit_sel !== 2'd2 || digit_out !== 4'd2) begin
      failures++;
      $display("FAIL tick_at_latch got done=%b sel=%0d out=%0d want 1 2 2",
               done, digit_sel, digit_out);
    end
    @(negedge clk);
    scan_tick = 1'b1;
    @(negedge clk);
    scan_tick = 1'b0;
    checks++;
    if (digit_sel !== 2'd3 || digit_out !== 4'd5) begin
      failures++;
      $display("FAIL tick_after_latch got sel=%0d out=%0d want 3 5", digit_sel, digit_out);
    end
    $display("test_scan: sel=%0d out=%0d", digit_sel, digit_out);
  endtask

  initial begin
    reset     = 1'b1;
    bin_in    = '0;
    start     = 1'b0;
    scan_tick = 1'b0;
    test_reset();
    test_convert_1234();
    test_max_zero();
    test_overflow();
    test_restart_ignored();
    test_reset_abort();
    test_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
